// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Buffer entries carry the fetched word with its PC and access-fault flag.
package ifu_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ifu_fifo.sv
// Flushable in-order entry buffer; a pushed entry is visible on rd_data the next cycle.
// No internal overflow guard: the caller's credit scheme bounds pushes, pops only when count != 0.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, credit-limited imem requests, in-order buffer to the decoder; redirect flushes all.
// Entries appear one cycle after their response; requests stop while buffer + in-flight reach FIFO_DEPTH. IFU_PERF_CNT_EN adds perf counters.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [63:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        out_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] in_flight;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    fifo_entry_t   wr_entry;
    fifo_entry_t   rd_entry;

    assign imem_req_valid = !rst && (state == ST_FETCH)
                            && (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign in_flight      = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign pop            = out_valid && out_ready;

    // Once discards are drained, live fetches have consecutive addresses ending just below pc.
    always_comb begin
        wr_entry.pc   = pc - {{(64 - CW - 2){1'b0}}, outstanding, 2'b00};
        wr_entry.inst = imem_rsp_err ? INST_NOP : imem_rsp_data;
        wr_entry.err  = imem_rsp_err;
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .push    (rsp_keep),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (occupancy)
    );

    assign out_valid = (occupancy != '0);
    assign out_inst  = rd_entry.inst;
    assign out_pc    = rd_entry.pc;
    assign out_err   = rd_entry.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= PC_RESET;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= in_flight;
            if (redirect_valid) begin
                pc      <= redirect_pc & ~64'd3;
                discard <= in_flight;
            end else begin
                if (req_fire) pc <= pc + 64'd4;
                if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_FETCH;
        end else if (rsp_keep && imem_rsp_err) begin
            state_nxt = ST_HALT;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (req_fire)               perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: queue-based reference model checked every cycle, directed corner cases,
// a redirect/alignment vector table and randomized traffic.
module tb_ifu;
    import ifu_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [63:0] PC0   = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_err;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu #(.PC_RESET(PC0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_err        (out_err)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] inst; logic err; } ent_t;
    typedef struct { logic [63:0] addr; bit live; } fly_t;
    typedef struct { logic [63:0] rpc; logic [63:0] a0; logic [63:0] a1; } vec_t;

    ent_t        m_fifo[$];
    fly_t        m_fly[$];
    logic [63:0] m_pc;
    bit          m_halt;
    longint      m_fetch;
    longint      m_stall;
    logic [63:0] req_log[$];
    ent_t        out_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int req_rdy_pct, rsp_pct, out_rdy_pct, err_pct, redir_pct;
    bit          redir_now;
    logic [63:0] redir_target;
    logic [63:0] err_at_addr;

    function automatic bit pct(int p);
        return (int'($urandom_range(99)) < p);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic missing(string name, int i);
        checks++;
        errors++;
        $display("FAIL %s: log entry %0d never appeared (cycle %0d)", name, i, cyc);
    endtask

    task automatic chk_req(string name, int i, logic [63:0] exp);
        if (i < req_log.size()) chk(name, req_log[i], exp);
        else missing(name, i);
    endtask

    task automatic chk_out(string name, int i, logic [63:0] exp);
        if (i < out_log.size()) chk(name, out_log[i].pc, exp);
        else missing(name, i);
    endtask

    task automatic knobs(int rq, int rs, int od, int er, int rd);
        req_rdy_pct = rq; rsp_pct = rs; out_rdy_pct = od; err_pct = er; redir_pct = rd;
    endtask

    task automatic quiet_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
        redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    endtask

    task automatic model_reset();
        m_fifo.delete(); m_fly.delete();
        m_pc = PC0; m_halt = 0; m_fetch = 0; m_stall = 0;
    endtask

    task automatic clear_logs();
        req_log.delete(); out_log.delete();
    endtask

    task automatic redirect_to(logic [63:0] target);
        redir_now = 1; redir_target = target;
        cycle();
        clear_logs();
    endtask

    // One clock: compare DUT against the model, drive memory/decoder/redirect, advance the model.
    task automatic cycle();
        bit exp_req, exp_ov, fire, rsp, pop, redir;
        fly_t f;
        logic [63:0] rpc;
        @(negedge clk);
        exp_req = !m_halt && (m_fifo.size() + m_fly.size() < DEPTH);
        exp_ov  = (m_fifo.size() != 0);
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", out_pc, m_fifo[0].pc);
            chk("out_inst", out_inst, m_fifo[0].inst);
            chk("out_err", out_err, m_fifo[0].err);
        end
        imem_req_ready = pct(req_rdy_pct);
        rsp = (m_fly.size() != 0) && pct(rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 0;
        if (rsp) imem_rsp_err = (m_fly[0].addr == err_at_addr) || pct(err_pct);
        redir = redir_now || pct(redir_pct);
        rpc   = redir_now ? redir_target : {$urandom, $urandom};
        redir_now = 0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready = pct(out_rdy_pct);
        fire = exp_req && imem_req_ready;
        pop  = exp_ov && out_ready;
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (out_valid && out_ready && !redir) out_log.push_back('{out_pc, out_inst, out_err});
        @(posedge clk);
        cyc++;
        if (fire) m_fetch++;
        if (exp_ov && !out_ready) m_stall++;
        if (rsp) begin
            f = m_fly.pop_front();
            if (!redir && f.live) begin
                m_fifo.push_back('{f.addr, imem_rsp_err ? INST_NOP : imem_rsp_data, imem_rsp_err});
                if (imem_rsp_err) m_halt = 1;
            end
        end
        if (pop && !redir) void'(m_fifo.pop_front());
        if (fire) begin
            m_fly.push_back('{m_pc, 1'b1});
            m_pc += 64'd4;
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_fly[i]) m_fly[i].live = 0;
            m_pc   = {rpc[63:2], 2'b00};
            m_halt = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   found;
        vecs[0] = '{64'h0000_0000_8000_0102, 64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104};
        vecs[1] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4};

        rst = 1;
        quiet_inputs();
        model_reset();
        knobs(100, 100, 100, 0, 0);
        redir_now = 0; redir_target = '0; err_at_addr = '1;

        repeat (3) @(negedge clk);
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_out_valid", out_valid, 0);
        rst = 0;

        // Sequential fetch after reset with a 1-cycle memory.
        clear_logs();
        repeat (12) cycle();
        chk_req("t1_addr0", 0, PC0);
        chk_req("t1_addr1", 1, PC0 + 64'd4);
        chk_req("t1_addr2", 2, PC0 + 64'd8);
        chk_out("t1_out0", 0, PC0);
        chk_out("t1_out1", 1, PC0 + 64'd4);
        chk_out("t1_out2", 2, PC0 + 64'd8);

        // Decoder stalled: buffer fills to DEPTH, requests stop, then drains in order.
        knobs(100, 100, 0, 0, 0);
        redirect_to(64'h0000_0000_8000_1000);
        repeat (10) cycle();
        #1;
        chk("t2_req_valid_drop", imem_req_valid, 0);
        chk("t2_buffered", req_log.size(), DEPTH);
        chk("t2_head_pc", out_pc, 64'h0000_0000_8000_1000);
        knobs(100, 100, 100, 0, 0);
        clear_logs();
        repeat (8) cycle();
        chk_out("t2_drain0", 0, 64'h0000_0000_8000_1000);
        chk_out("t2_drain1", 1, 64'h0000_0000_8000_1004);
        chk_out("t2_drain2", 2, 64'h0000_0000_8000_1008);

        // Two fetches outstanding, buffer empty, then redirect to a misaligned PC.
        knobs(100, 0, 100, 0, 0);
        repeat (6) cycle();
        #1;
        chk("t3_pre_req_valid", imem_req_valid, 0);
        chk("t3_pre_out_valid", out_valid, 0);
        knobs(100, 100, 100, 0, 0);
        redirect_to(64'h0000_0000_8000_0102);
        repeat (8) cycle();
        chk_req("t3_next_addr", 0, 64'h0000_0000_8000_0100);
        chk_out("t3_first_out", 0, 64'h0000_0000_8000_0100);

        // Access fault halts fetching until a redirect.
        err_at_addr = 64'h0000_0000_8000_0010;
        redirect_to(PC0);
        repeat (20) cycle();
        #1;
        chk("t4_halt_req_valid", imem_req_valid, 0);
        chk("t4_req_count_bounded", (req_log.size() == 5) || (req_log.size() == 6), 1);
        chk_out("t4_err_entry_pc", 4, 64'h0000_0000_8000_0010);
        if (out_log.size() > 4) begin
            chk("t4_err_flag", out_log[4].err, 1);
            chk("t4_err_inst", out_log[4].inst, 64'h13);
        end
        err_at_addr = '1;
        redirect_to(64'h0000_0000_8000_0200);
        repeat (6) cycle();
        chk_req("t4_resume_addr", 0, 64'h0000_0000_8000_0200);

        // Redirect coinciding with a response and an output handshake.
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_fifo.size() != 0 && m_fly.size() != 0) found = 1;
            else cycle();
        end
        chk("t5_setup_found", found, 1);
        redirect_to(64'h0000_0000_8000_0300);
        #1;
        chk("t5_out_valid_cleared", out_valid, 0);
        repeat (8) cycle();
        chk_out("t5_first_out", 0, 64'h0000_0000_8000_0300);
        chk_out("t5_second_out", 1, 64'h0000_0000_8000_0304);

        // Redirect alignment and PC wrap vectors.
        for (int v = 0; v < 4; v++) begin
            redirect_to(vecs[v].rpc);
            repeat (6) cycle();
            chk_req($sformatf("vec%0d_addr0", v), 0, vecs[v].a0);
            chk_req($sformatf("vec%0d_addr1", v), 1, vecs[v].a1);
            chk_out($sformatf("vec%0d_out0", v), 0, vecs[v].a0);
        end

        // Asynchronous reset in the middle of traffic.
        knobs(100, 100, 0, 0, 0);
        repeat (6) cycle();
        #1;
        chk("t6_pre_out_valid", out_valid, 1);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("t6_rst_req_valid", imem_req_valid, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        knobs(100, 100, 100, 0, 0);
        clear_logs();
        repeat (6) cycle();
        chk_req("t6_restart_addr", 0, PC0);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 6; blk++) begin
            knobs(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                  int'($urandom_range(10, 100)), 3, 4);
            repeat (500) cycle();
        end

`ifdef IFU_PERF_CNT_EN
        #1;
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
